// File: rtl/cpu_pkg.sv
// Shared CPU definitions: next-PC select encodings, NOP/halt constants, datapath width.
package cpu_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        PCSRC_SEQ = 2'b00,
        PCSRC_BR  = 2'b01,
        PCSRC_J   = 2'b10,
        PCSRC_JR  = 2'b11
    } pcsrc_e;

    localparam logic [XLEN-1:0] NOP_INS     = 32'h0000_0000;
    localparam logic [5:0]      HALT_OPCODE = 6'b111111;

endpackage

// File: rtl/if_fetch_stage_next_pc_sel.sv
// Combinational next-PC mux plus legality check (alignment and memory range) of the chosen target.
module next_pc_sel
    import cpu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 256
) (
    input  logic [XLEN-1:0] pc,
    input  pcsrc_e          pc_src,
    input  logic [XLEN-1:0] imm32,
    input  logic [25:0]     j_addr,
    input  logic [XLEN-1:0] reg_addr,
    input  logic [XLEN-1:0] if_id_pc4,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] next_pc,
    output logic            illegal
);

    localparam logic [XLEN-1:0] LAST_PC = XLEN'(MEM_BYTES) - XLEN'(4);

    assign pc_plus4 = pc + XLEN'(4);

    // Branch and jump bases are the ID-stage PC+4, since both resolve in decode.
    always_comb begin
        next_pc = pc_plus4;
        case (pc_src)
            PCSRC_SEQ: next_pc = pc_plus4;
            PCSRC_BR:  next_pc = if_id_pc4 + (imm32 << 2);
            PCSRC_J:   next_pc = {if_id_pc4[31:28], j_addr, 2'b00};
            PCSRC_JR:  next_pc = reg_addr;
            default:   next_pc = pc_plus4;
        endcase
    end

    assign illegal = (next_pc[1:0] != 2'b00) || (next_pc > LAST_PC);

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection and IF/ID pipeline register.
// Optional halt-opcode detection is enabled by defining IF_HALT_DETECT_EN.
module if_fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0]  RESET_PC  = 32'h0000_0000,
    parameter int unsigned  MEM_BYTES = 256
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        Stall,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] Imm32,
    input  logic [25:0] JAddr,
    input  logic [31:0] RegAddr,
    output logic [31:0] Iaddr,
    output logic        RW,
    input  logic [31:0] IDataIn,
    output logic [31:0] IF_ID_Ins,
    output logic [31:0] IF_ID_PC4,
    output logic        IF_ID_Valid,
    output logic        Fault
);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] next_pc;
    logic            illegal;
    logic            halted;
    pcsrc_e          pc_src;

    assign pc_src = pcsrc_e'(PCSrc);

    next_pc_sel #(
        .MEM_BYTES (MEM_BYTES)
    ) u_next_pc_sel (
        .pc        (pc),
        .pc_src    (pc_src),
        .imm32     (Imm32),
        .j_addr    (JAddr),
        .reg_addr  (RegAddr),
        .if_id_pc4 (IF_ID_PC4),
        .pc_plus4  (pc_plus4),
        .next_pc   (next_pc),
        .illegal   (illegal)
    );

    assign Iaddr = pc;
    assign RW    = ~Reset & ~Fault & ~halted;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            pc          <= RESET_PC;
            IF_ID_Ins   <= NOP_INS;
            IF_ID_PC4   <= '0;
            IF_ID_Valid <= 1'b0;
            Fault       <= 1'b0;
            halted      <= 1'b0;
        end else if (Fault || halted) begin
            IF_ID_Ins   <= NOP_INS;
            IF_ID_Valid <= 1'b0;
        end else if (Stall) begin
            pc          <= pc;
        end else if (illegal) begin
            Fault       <= 1'b1;
            IF_ID_Ins   <= NOP_INS;
            IF_ID_Valid <= 1'b0;
        end else begin
            pc <= next_pc;
            if (pc_src == PCSRC_SEQ) begin
                IF_ID_Ins   <= IDataIn;
                IF_ID_PC4   <= pc_plus4;
                IF_ID_Valid <= 1'b1;
`ifdef IF_HALT_DETECT_EN
                if (IDataIn[31:26] == HALT_OPCODE) begin
                    halted <= 1'b1;
                end
`endif
            end else begin
                // Wrong-path word fetched this cycle is squashed; PC4 keeps the last real value.
                IF_ID_Ins   <= NOP_INS;
                IF_ID_Valid <= 1'b0;
            end
        end
    end

endmodule
